// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : Row-scanning keypad matrix controller. Drives one row low at a
//               time, samples the column lines at the end of each row slot,
//               classifies every full frame as none / single key / multiple
//               keys (multiple keys are ignored as possible ghosts), debounces
//               presses and releases over whole frames, and queues one key
//               code per debounced press in a show-ahead FIFO.
//
//               Optional feature macro: KEYPAD_AUTOREPEAT_EN
//                 When defined, a held key re-queues its code after 32 more
//                 held frames and then every 8 held frames. Frames spent in
//                 the release-wait state pause the repeat timer.
//
// Ports       : clk        - clock
//               resetn     - asynchronous active-low reset
//               col        - column sense lines, low = contact on driven row
//               row        - row drive lines, one-hot active-low
//               key_code   - head-of-FIFO code (row_index*COLS + col_index)
//               key_valid  - FIFO non-empty, key_code valid
//               key_ready  - consumer accepts the head entry
//               fifo_count - number of buffered events
//               overflow   - sticky flag: an event was dropped (FIFO full)
//               clr_ovf    - synchronous clear of overflow
//
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SETTLE     = 8,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int KW         = $clog2(ROWS * COLS)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               row,
    output logic [KW-1:0]                 key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_RW = $clog2(ROWS);
    localparam int c_CW = $clog2(COLS);
    localparam int c_SW = $clog2(SETTLE);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_DW = $clog2(DEBOUNCE + 1);

    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST    = c_RW'(ROWS - 1);
    localparam logic [c_DW-1:0] c_DB_LAST     = c_DW'(DEBOUNCE - 1);
    localparam logic [c_DW-1:0] c_DB_ONE      = c_DW'(1);
    localparam logic [c_AW:0]   c_CNT_FULL    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE     = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE     = c_AW'(1);
    localparam logic [ROWS-1:0] c_ROW_RESET   = {{(ROWS - 1){1'b1}}, 1'b0};

    // ------------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------------
    logic [c_SW-1:0] r_settle_cnt;
    logic [c_RW-1:0] r_row_idx;
    logic [ROWS-1:0] r_row;
    logic [1:0]      r_frame_hits;   // 0, 1 or 2 (= two or more) low columns so far
    logic [KW-1:0]   r_frame_code;   // code of the single hit seen so far

    logic [COLS-1:0] w_col_low;
    logic [1:0]      w_col_hits;
    logic [c_CW-1:0] w_col_idx;
    logic [KW-1:0]   w_here_code;
    logic [2:0]      w_hit_sum;
    logic [1:0]      w_hits_sat;
    logic            w_sample;
    logic            w_frame_end;
    logic            w_frame_single;
    logic [KW-1:0]   w_frame_code;

    // Count low columns on the currently driven row (saturating at 2) and
    // remember the index of one of them; only meaningful when exactly one.
    always_comb begin
        w_col_low  = ~col;
        w_col_hits = 2'd0;
        w_col_idx  = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_col_low[c]) begin
                w_col_idx = c_CW'(c);
                if (w_col_hits != 2'd2) begin
                    w_col_hits = w_col_hits + 2'd1;
                end
            end
        end
    end

    assign w_here_code    = KW'(int'(r_row_idx) * COLS + int'(w_col_idx));
    assign w_hit_sum      = {1'b0, r_frame_hits} + {1'b0, w_col_hits};
    assign w_hits_sat     = (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
    assign w_sample       = (r_settle_cnt == c_SETTLE_LAST);
    assign w_frame_end    = w_sample && (r_row_idx == c_ROW_LAST);
    // Classification includes the sample being taken this cycle, so the
    // debouncer sees the complete frame on the frame-end edge.
    assign w_frame_single = (w_hits_sat == 2'd1);
    assign w_frame_code   = (w_col_hits == 2'd1) ? w_here_code : r_frame_code;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_settle_cnt <= '0;
            r_row_idx    <= '0;
            r_row        <= c_ROW_RESET;
            r_frame_hits <= 2'd0;
            r_frame_code <= '0;
        end else if (w_sample) begin
            r_settle_cnt <= '0;
            // Rotating the active-low bit keeps row glitch-free and one-hot.
            r_row        <= {r_row[ROWS-2:0], r_row[ROWS-1]};
            if (w_frame_end) begin
                r_row_idx    <= '0;
                r_frame_hits <= 2'd0;
                r_frame_code <= '0;
            end else begin
                r_row_idx    <= r_row_idx + c_RW'(1);
                r_frame_hits <= w_hits_sat;
                r_frame_code <= w_frame_code;
            end
        end else begin
            r_settle_cnt <= r_settle_cnt + c_SW'(1);
        end
    end

    assign row = r_row;

    // ------------------------------------------------------------------------
    // Frame-rate debouncer
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

    db_state_t       r_db_state;
    logic [KW-1:0]   r_db_code;
    logic [c_DW-1:0] r_db_cnt;
    logic            r_push;         // one-cycle strobe, write data is r_db_code
    logic            w_match;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [5:0]      r_rep_cnt;
    logic            r_rep_first;    // still waiting for the long initial delay
`endif

    assign w_match = w_frame_single && (w_frame_code == r_db_code);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_db_state  <= ST_IDLE;
            r_db_code   <= '0;
            r_db_cnt    <= '0;
            r_push      <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_push <= 1'b0;
            if (w_frame_end) begin
                case (r_db_state)
                    ST_IDLE: begin
                        if (w_frame_single) begin
                            r_db_code <= w_frame_code;
                            r_db_cnt  <= c_DB_ONE;
                            if (DEBOUNCE == 1) begin
                                r_push     <= 1'b1;
                                r_db_state <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                                r_rep_cnt   <= '0;
                                r_rep_first <= 1'b1;
`endif
                            end else begin
                                r_db_state <= ST_PRESS_WAIT;
                            end
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (w_match) begin
                            if (r_db_cnt == c_DB_LAST) begin
                                r_push     <= 1'b1;
                                r_db_state <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                                r_rep_cnt   <= '0;
                                r_rep_first <= 1'b1;
`endif
                            end else begin
                                r_db_cnt <= r_db_cnt + c_DB_ONE;
                            end
                        end else begin
                            r_db_state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (!w_match) begin
                            r_db_cnt   <= c_DB_ONE;
                            r_db_state <= (DEBOUNCE == 1) ? ST_IDLE : ST_RELEASE_WAIT;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        else if (r_rep_cnt == (r_rep_first ? 6'd31 : 6'd7)) begin
                            r_push      <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 6'd1;
                        end
`endif
                    end
                    ST_RELEASE_WAIT: begin
                        // The repeat timer is left untouched here so that a
                        // bounce back to HELD resumes where it stopped.
                        if (w_match) begin
                            r_db_state <= ST_HELD;
                        end else if (r_db_cnt == c_DB_LAST) begin
                            r_db_state <= ST_IDLE;
                        end else begin
                            r_db_cnt <= r_db_cnt + c_DB_ONE;
                        end
                    end
                    default: begin
                        r_db_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------------
    logic [KW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    assign w_full = (r_count == c_CNT_FULL);
    assign w_pop  = key_valid && key_ready;
    // A push into a full FIFO is still accepted when the head leaves this edge.
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_db_code;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A drop on the same edge as a clear wins, so no loss goes unseen.
            if (r_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign key_valid  = (r_count != '0);
    assign key_code   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_scanner
// Description : Self-checking bench for keypad_matrix_scanner (4x4 matrix,
//               SETTLE=4, DEBOUNCE=3, FIFO_DEPTH=4, 16-cycle frames). A
//               frame-level reference model predicts the FIFO contents and
//               flags, which are compared against the DUT every cycle;
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    // Pressed keys, bit index = row*4 + col; only changed at frame starts.
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_matrix_scanner #(
        .ROWS       (4),
        .COLS       (4),
        .SETTLE     (4),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .col        (col),
        .row        (row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r * 4 + c]) col[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model, frame level. cyc = clock edges since reset release,
    // so a frame ends on cycles with cyc%16 == 15. A debounced press is
    // pushed during the following cycle and is visible one cycle later.
    // ------------------------------------------------------------------------
    int cyc = 0;
    int q[$];
    int m_ovf = 0;
    int push_now = 0;
    int ph = 0;        // 0 idle, 1 press-wait, 2 held, 3 release-wait
    int dcode = 0;
    int dcnt = 0;

    always @(posedge clk) begin
        int push_cur;
        int pop;
        int fcode;
        int same;
        if (!resetn) begin
            cyc = 0; q.delete(); m_ovf = 0; push_now = 0;
            ph = 0; dcode = 0; dcnt = 0;
        end else begin
            push_cur = push_now;
            push_now = 0;
            pop = (q.size() != 0 && key_ready) ? 1 : 0;
            if (pop != 0) void'(q.pop_front());
            if (push_cur != 0 && q.size() < 4) q.push_back(dcode);
            if (push_cur != 0 && q.size() == 4 && pop == 0 && q[3] != dcode + 100) begin
                // Dropped only when the queue was already full without a pop.
            end
            if (push_cur != 0 && pop == 0 && m_full_before(q.size(), push_cur)) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (cyc % 16 == 15) begin
                fcode = -1;
                if ($countones(keys) == 1) begin
                    for (int k = 0; k < 16; k++) if (keys[k]) fcode = k;
                end
                same = (fcode >= 0 && fcode == dcode) ? 1 : 0;
                case (ph)
                    0: if (fcode >= 0) begin dcode = fcode; dcnt = 1; ph = 1; end
                    1: if (same != 0) begin
                           dcnt++;
                           if (dcnt == 3) begin push_now = 1; ph = 2; end
                       end else ph = 0;
                    2: if (same == 0) begin dcnt = 1; ph = 3; end
                    default: if (same != 0) ph = 2;
                             else begin dcnt++; if (dcnt == 3) ph = 0; end
                endcase
            end
            cyc++;
        end
    end

    // Tracks whether the last no-pop push found the queue full (a drop).
    int last_size_before = 0;
    always @(negedge clk) last_size_before = q.size();
    function automatic bit m_full_before(input int size_after, input int pushed);
        return (pushed != 0 && last_size_before == 4 && size_after == 4);
    endfunction

    // Per-cycle comparison against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        chk("row", row, resetn ? int'(~(4'b0001 << ((cyc / 4) % 4)) & 4'hF) : 4'b1110);
        chk("key_valid", key_valid, (q.size() != 0) ? 1 : 0);
        chk("fifo_count", fifo_count, q.size());
        chk("overflow", overflow, m_ovf);
        if (q.size() != 0) chk("key_code", key_code, q[0]);
        else if (!resetn) chk("key_code_reset", key_code, 0);
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at negedge times)
    // ------------------------------------------------------------------------
    task automatic hold_frames(input logic [15:0] k, input int n);
        while (cyc % 16 != 0) @(negedge clk);
        keys = k;
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic press(input int code);
        hold_frames(16'h0001 << code, 3);
        hold_frames(16'h0000, 3);
    endtask

    task automatic pop_expect(input string name, input int exp);
        chk({name, "_valid"}, key_valid, 1);
        chk(name, key_code, exp);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!key_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int t1_codes[5] = '{1, 4, 9, 14, 3};
    int t2_codes[4] = '{0, 5, 10, 15};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_row", row, 4'b1110);
        chk("reset_valid", key_valid, 0);
        chk("reset_code", key_code, 0);
        resetn = 1'b1;

        // Single key row 1 / col 2: one event, code 6, 49 cycles after press start.
        while (cyc % 16 != 0) @(negedge clk);
        keys = 16'h0040;
        wait_valid(lat);
        chk("press_latency", lat, 49);
        pop_expect("press_code", 6);
        hold_frames(16'h0000, 4);
        chk("no_release_event", fifo_count, 0);

        // Two keys together for 10 frames: rejected as a ghost pattern.
        hold_frames(16'h0021, 10);
        hold_frames(16'h0000, 1);
        chk("multi_rejected", fifo_count, 0);

        // Bounce for 8 frames then stable for 3: exactly one event.
        for (int i = 0; i < 8; i++) hold_frames((i % 2 == 0) ? 16'h0040 : 16'h0000, 1);
        hold_frames(16'h0040, 3);
        hold_frames(16'h0000, 3);
        chk("bounce_count", fifo_count, 1);
        pop_expect("bounce_code", 6);

        // Five presses without consuming: four kept in order, one dropped.
        foreach (t1_codes[i]) press(t1_codes[i]);
        chk("full_count", fifo_count, 4);
        chk("full_overflow", overflow, 1);
        foreach (t1_codes[i]) if (i < 4) pop_expect("order_code", t1_codes[i]);
        chk("drained_count", fifo_count, 0);
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with a pop on the push cycle: new entry accepted at the tail.
        foreach (t2_codes[i]) press(t2_codes[i]);
        chk("refill_count", fifo_count, 4);
        hold_frames(16'h0080, 3);          // returns on the push cycle of code 7
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_ovf", overflow, 0);
        hold_frames(16'h0000, 3);
        pop_expect("tail_code0", 5);
        pop_expect("tail_code1", 10);
        pop_expect("tail_code2", 15);
        pop_expect("tail_code3", 7);

        // Reset mid press-wait with one event buffered.
        press(2);
        chk("pre_reset_count", fifo_count, 1);
        hold_frames(16'h2000, 1);
        repeat (8) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_valid", key_valid, 0);
        chk("midreset_row", row, 4'b1110);
        chk("midreset_count", fifo_count, 0);
        resetn = 1'b1;
        wait_valid(lat);
        chk("post_reset_latency", lat, 49);
        pop_expect("post_reset_code", 13);
        hold_frames(16'h0000, 3);
        chk("final_count", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 Parameter ROWS, 4, number of matrix rows driven (2..8).
REQ-002 Parameter COLS, 4, number of matrix columns sampled (2..8).
REQ-003 Parameter SETTLE, 8, clk cycles each row is driven before its columns are sampled (>=2).
REQ-004 Parameter DEBOUNCE, 3, consecutive identical frames required to accept a press or a release (>=1).
REQ-005 Parameter FIFO_DEPTH, 4, key-event buffer entries (power of two, >=2).
REQ-006 Parameter KW, clog2(ROWS*COLS), key code width.
REQ-007 clk  input  1  clock.
REQ-008 resetn  input  1  reset: asynchronous, active-low.
REQ-009 col  input  COLS  column sense lines; low = key contact on the driven row.
REQ-010 row  output  ROWS  row drive lines; one-hot active-low, exactly one bit low at all times.
REQ-011 key_code  output  KW  head-of-FIFO key code = row_index*COLS + col_index.
REQ-012 key_valid  output  1  FIFO non-empty; key_code valid.
REQ-013 key_ready  input  1  consumer accepts the head entry when key_valid=1.
REQ-014 fifo_count  output  clog2(FIFO_DEPTH)+1  number of buffered events.
REQ-015 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-016 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-017 The scan FSM SHALL drive row r low for SETTLE cycles and sample col on the last cycle, then advance to r+1, wrapping ROWS-1 -> 0; one frame = ROWS*SETTLE cycles.
REQ-018 A frame SHALL be classified as NONE (no low col), SINGLE(code) (exactly one low col bit across all rows), or MULTI (two or more); MULTI SHALL be treated as NONE (ghost rejection).
REQ-019 The debouncer SHALL have states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, evaluated once per frame end.
REQ-020 IDLE -> PRESS_WAIT on SINGLE(c), latch c, frame counter=1; PRESS_WAIT counts identical SINGLE(c) frames, differing frame -> IDLE.
REQ-021 On reaching DEBOUNCE identical frames, the FSM SHALL push c to the FIFO exactly once and enter HELD.
REQ-022 HELD -> RELEASE_WAIT on any frame not SINGLE(c); RELEASE_WAIT -> IDLE after DEBOUNCE consecutive non-SINGLE(c) frames, back to HELD on SINGLE(c); no push on release.
REQ-023 FIFO SHALL be show-ahead: key_code reflects the head entry combinationally from storage whenever key_valid=1.
REQ-024 Pop occurs on the clk edge with key_valid=1 and key_ready=1; key_ready with key_valid=0 SHALL be ignored.
REQ-025 Push when full with no pop in the same cycle SHALL be dropped and set overflow on the next edge; push while full with simultaneous pop SHALL be accepted, fifo_count unchanged.
REQ-026 Push and pop in the same cycle on a non-empty, non-full FIFO SHALL leave fifo_count unchanged.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-028 clr_ovf SHALL clear overflow; if clr_ovf coincides with a dropped push, overflow SHALL remain 1.
REQ-029 Event latency: push occurs on the cycle after the frame end completing the DEBOUNCE-th frame; key_valid rises one cycle after push.

Reset
REQ-030 During and after resetn low: row = all ones except bit 0 low, scan counters 0, debouncer IDLE, FIFO empty, key_valid=0, fifo_count=0, overflow=0, key_code=0.
REQ-031 Reset asserted mid-frame or mid-debounce SHALL abandon the frame and discard all buffered events.

Configuration
REQ-032 Macro KEYPAD_AUTOREPEAT_EN: when defined, a key remaining in HELD SHALL re-push its code after 32 further frames, then every 8 frames while held; RELEASE_WAIT SHALL pause the repeat counter, and returning to HELD SHALL resume it.
REQ-033 Without KEYPAD_AUTOREPEAT_EN, exactly one event per debounced press SHALL be generated and no repeat logic SHALL exist.

Verification (ROWS=4, COLS=4, SETTLE=4, DEBOUNCE=3, FIFO_DEPTH=4; frame = 16 cycles)
REQ-034 Hold col=4'b1011 whenever row=4'b1101 (row 1, col 2) -> exactly one event key_code=6, key_valid within 3 frames+2 cycles of press start; none on release.
REQ-035 Press row0/col0 and row1/col1 simultaneously for 10 frames -> no event, fifo_count=0.
REQ-036 Key bounce alternating pressed/released each frame for 8 frames, then stable 3 frames -> exactly one event.
REQ-037 key_ready=0, five distinct debounced presses -> fifo_count=4, overflow=1, first four codes popped in press order; clr_ovf pulse -> overflow=0.
REQ-038 FIFO full, key_ready=1 on the cycle a new push occurs -> fifo_count stays 4, overflow stays 0, new code appears after the remaining entries.
REQ-039 resetn low mid-PRESS_WAIT with one buffered event -> key_valid=0, row=4'b1110, no event emitted after reset until a fresh 3-frame press.
